// File: rtl/uart_tx_fifo_if.sv
// Byte write port of the UART transmitter: one byte per valid/ready handshake.
interface uart_tx_fifo_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1/8N2 UART transmitter behind a small byte FIFO; frames are sent back to back
// while bytes remain queued, and the line idles high otherwise.
module uart_tx_fifo #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
  parameter int STOP_BITS    = 2,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                            CLOCK_50,
  input  logic                            reset_n,
  uart_tx_fifo_if.slave                   wr,
  output logic                            UART_TXD,
  output logic                            tx_busy,
  output logic                            tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [7:0]        shift;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic              push;
  logic              pop;
  logic              bit_end;

  assign wr.tx_ready = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign push        = wr.tx_valid && wr.tx_ready;
  assign bit_end     = (baud_cnt == BAUD_LAST);
  // The head byte leaves the FIFO when a new frame starts: from IDLE, or at the very end of STOP.
  assign pop = (fifo_count != '0) &&
               ((state == IDLE) || (state == STOP && bit_end && bit_idx == STOP_LAST));

  // NOTE: FIFO storage carries no reset; pointers and fifo_count alone define what is valid.
  always_ff @(posedge CLOCK_50) begin
    if (push) mem[wr_ptr] <= wr.tx_data;
  end

  // NOTE: non-blocking assignments so every flop samples values from before the edge.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state    <= IDLE;
      UART_TXD <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      shift    <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            shift    <= mem[rd_ptr];
            UART_TXD <= 1'b0;
            tx_busy  <= 1'b1;
            baud_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            UART_TXD <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx  <= '0;
              UART_TXD <= 1'b1;
              state    <= STOP;
            end else begin
              // shift[1] is the next bit because the register shifts on this same edge.
              bit_idx  <= bit_idx + 3'd1;
              shift    <= {1'b0, shift[7:1]};
              UART_TXD <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              tx_done <= 1'b1;
              if (pop) begin
                shift    <= mem[rd_ptr];
                UART_TXD <= 1'b0;
                state    <= START;
              end else begin
                tx_busy <= 1'b0;
                state   <= IDLE;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
UART transmitter for the FPGA-to-host direction of the serial link. It frames bytes as 8N2: 1 start bit, 8 data bits sent LSB first, no parity, 2 stop bits, at 115200 baud from the 50 MHz board clock. This matches the framing the host already uses into the board. A small FIFO with a valid/ready write port decouples producers (LED/status logic, image readback) from the slow serial line. Its UART_TXD output drives the board TX pin in fpga_top.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in baud
CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (integer division; 434), clock cycles per bit
STOP_BITS, 2, number of stop bits (legal values 1 or 2)
FIFO_DEPTH, 16, byte entries; must be a power of 2, at least 2

Ports:
CLOCK_50  input  1  system clock; all logic on rising edge
reset_n  input  1  synchronous, active-low reset
tx_data  input  8  byte to queue
tx_valid  input  1  tx_data valid this cycle
tx_ready  output  1  FIFO can accept; high when fifo_count < FIFO_DEPTH
UART_TXD  output  1  serial line, registered; idles high
tx_busy  output  1  high while a frame is on the line (state != IDLE)
tx_done  output  1  one-cycle pulse at the end of each frame's last stop bit
fifo_count  output  $clog2(FIFO_DEPTH+1)  bytes queued, excluding the byte being shifted

Behaviour:
- Reset: sampled on the CLOCK_50 edge with reset_n=0.
  - Outputs: UART_TXD=1, tx_busy=0, tx_done=0, fifo_count=0, tx_ready=1.
  - Internals: FIFO pointers cleared, FSM to IDLE, baud and bit counters cleared.
  - Reset mid-frame aborts the frame: line high on the next cycle, queued bytes discarded.
- Write: a byte is pushed on any edge where tx_valid && tx_ready. When tx_ready=0, tx_valid is ignored; no overflow state exists.
- Pop: the FSM pops the head byte into a shift register when leaving IDLE or STOP with the FIFO non-empty.
- Simultaneous push and pop in one cycle: fifo_count unchanged, both operations take effect.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are derived from fifo_count.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: UART_TXD=1. If FIFO non-empty, pop, set UART_TXD=0, go to START.
  - START: hold 0 for CLKS_PER_BIT cycles. Then drive shift[0] and go to DATA with bit index 0.
  - DATA: each bit is held CLKS_PER_BIT cycles. After bit 7, drive 1 and go to STOP.
  - STOP: hold 1 for STOP_BITS*CLKS_PER_BIT cycles. At the end, pulse tx_done. Then:
    - if FIFO non-empty: pop and drive 0, going straight to START with no idle gap;
    - else go to IDLE.
- Latency: a byte written at edge N into an empty FIFO with FSM in IDLE produces UART_TXD=0 after edge N+1. fifo_count reads 1 for exactly one cycle.
- Frame length is exactly (1+8+STOP_BITS)*CLKS_PER_BIT cycles: 4774 cycles = 95.48 us for the default parameters.
- Baud counter counts 0..CLKS_PER_BIT-1 and restarts on every bit boundary. Accumulated error comes only from integer division (434 vs 434.03).
- tx_busy goes high on the cycle UART_TXD first goes low. It stays high across back-to-back frames and goes low on the cycle the FSM enters IDLE.
- UART_TXD is driven directly from a flop with no combinational glitches.

Test Plan:
1. Reset, idle 100 cycles -> UART_TXD=1, tx_ready=1, fifo_count=0, tx_busy=0 throughout.
2. Push 0x55 once -> line low 434 cycles starting 1 cycle after the push; then 1,0,1,0,1,0,1,0, each 434 cycles; high 868 cycles; one tx_done pulse 4774 cycles after the start edge; tx_busy falls the same cycle.
3. Push 0x00..0x07 back-to-back, then 0xAA, 0x55, 0xFF -> 11 contiguous frames with no idle gap; decoded bytes in order; 11 tx_done pulses spaced 4774 cycles apart.
4. Hold tx_valid for 20 cycles with an incrementing byte while the line is busy -> exactly 16 accepted (tx_ready=0 once fifo_count=16); the first popped byte leaves fifo_count=15 and frees one slot; accepted bytes are transmitted in order; no byte is lost or duplicated.
5. Assert reset_n=0 for one cycle in the middle of DATA bit 3 with 5 bytes queued -> UART_TXD=1 the next cycle, fifo_count=0, tx_busy=0, no tx_done pulse; a subsequent push of 0xA5 transmits cleanly.
6. Loop UART_TXD back into the board UART receiver and send 0x00, 0x7E, 0x81, 0xFF -> receiver reports the same 4 bytes with no frame_error.
